// File: rtl/regex_stream_ctrl_if.sv
// Stream/detector/result bundle for regex_stream_ctrl.
//   in_*      : upstream character stream (valid/ready handshake)
//   det_*     : per-character drive to, and response from, the regex detector
//   res_*     : downstream match report (valid/ready handshake)
//   done, timeout_err, char_count : stream status
// modport master : the controller side
// modport slave  : the environment (upstream, detector, downstream)
interface regex_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        det_reset;
  logic [7:0]  det_char;
  logic        det_last;
  logic        det_rdy;
  logic        det_match;
  logic [31:0] det_start;
  logic [31:0] det_end;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_start;
  logic [31:0] res_end;
  logic        done;
  logic        timeout_err;
  logic [31:0] char_count;

  modport master (
    input  in_valid, in_char, in_last, det_rdy, det_match, det_start, det_end, res_ready,
    output in_ready, det_reset, det_char, det_last, res_valid, res_start, res_end,
           done, timeout_err, char_count
  );

  modport slave (
    output in_valid, in_char, in_last, det_rdy, det_match, det_start, det_end, res_ready,
    input  in_ready, det_reset, det_char, det_last, res_valid, res_start, res_end,
           done, timeout_err, char_count
  );
endinterface

// File: rtl/regex_stream_ctrl.sv
// Sequences one character at a time through a regex detector: accepts a
// character, pulses det_reset for RESET_CYCLES, waits (bounded by TIMEOUT)
// for the detector verdict, forwards matches downstream and pulses done
// after the last character of a stream.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset
//   bus   : regex_stream_ctrl_if.master (stream in, detector, report out, status)
// Parameters:
//   RESET_CYCLES : det_reset high time per character, 1..15
//   TIMEOUT      : max WAIT cycles for det_rdy, 1..65535
module regex_stream_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  regex_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT,
    REPORT,
    FINISH
  } state_t;

  localparam logic [3:0]  PULSE_LOAD = 4'(RESET_CYCLES);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  pulse_cnt;
  logic [15:0] wait_cnt;

  // All outputs are registered; in_ready is raised on every transition into
  // IDLE so it is 1 throughout IDLE except the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pulse_cnt       <= '0;
      wait_cnt        <= '0;
      bus.in_ready    <= 1'b0;
      bus.det_reset   <= 1'b1;
      bus.det_char    <= '0;
      bus.det_last    <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_start   <= '0;
      bus.res_end     <= '0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.char_count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // below reads the pre-edge values, regardless of statement order.
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_ready && bus.in_valid) begin
            bus.det_char  <= bus.in_char;
            bus.det_last  <= bus.in_last;
            if (bus.char_count != '1) bus.char_count <= bus.char_count + 32'd1;
            pulse_cnt     <= PULSE_LOAD;
            bus.det_reset <= 1'b1;
            bus.in_ready  <= 1'b0;
            state         <= PULSE;
          end else begin
            bus.in_ready  <= 1'b1;
            bus.det_reset <= 1'b0;
          end
        end

        // det_rdy is deliberately not looked at here: the detector is still
        // being cleared and its outputs are meaningless.
        PULSE: begin
          if (pulse_cnt == 4'd1) begin
            bus.det_reset <= 1'b0;
            wait_cnt      <= '0;
            state         <= WAIT;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end

        // A verdict arriving in the timeout cycle wins over the timeout.
        WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (bus.det_rdy && bus.det_match) begin
            bus.res_start <= bus.det_start;
            bus.res_end   <= bus.det_end;
            bus.res_valid <= 1'b1;
            state         <= REPORT;
          end else if (bus.det_rdy || wait_cnt == WAIT_LAST) begin
            if (!bus.det_rdy) bus.timeout_err <= 1'b1;
            if (bus.det_last) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        REPORT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (bus.det_last) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        FINISH: begin
          bus.char_count <= '0;
          bus.in_ready   <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regex_stream_ctrl.sv
// Directed bench for regex_stream_ctrl. A driver issues characters and plays
// the detector; expected reports and done pulses go into queues that an
// independent negedge monitor pops whenever the DUT presents them.
module tb_regex_stream_ctrl;
  localparam int RC = 2;
  localparam int TO = 8;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
  } rep_t;

  typedef enum {M_NORMAL, M_HOLD, M_ABORT} mode_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regex_stream_ctrl_if bus ();

  regex_stream_ctrl #(.RESET_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int acc_seen = 0;
  int exp_count = 0;
  rep_t rep_q[$];
  int unsigned done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one character and act as the detector for it.
  // delay < 0 : detector never answers (timeout path).
  task automatic send_char(input logic [7:0] c, input logic last, input int delay,
                           input logic match, input logic [31:0] s, input logic [31:0] e,
                           input mode_t mode, input logic keep_valid, input logic noise);
    int n;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    tick();
    exp_count++;
    if (keep_valid) begin
      bus.in_char = 8'hEE;
      bus.in_last = 1'b0;
    end else begin
      bus.in_valid = 1'b0;
    end
    check("det_char", bus.det_char, c);
    check("det_last", bus.det_last, last);
    if (noise) begin
      bus.det_rdy   = 1'b1;
      bus.det_match = 1'b1;
      bus.det_start = 32'hFF;
      bus.det_end   = 32'hFF;
    end
    n = 0;
    while (bus.det_reset && n < 20) begin
      check("in_ready_busy", bus.in_ready, 0);
      tick();
      n++;
    end
    check("det_reset_len", n, RC);
    bus.det_rdy   = 1'b0;
    bus.det_match = 1'b0;
    check("det_char_hold", bus.det_char, c);

    if (delay < 0) begin
      for (int i = 0; i <= TO; i++) begin
        check("timeout_err_timing", bus.timeout_err, (i == TO));
        if (i < TO) tick();
      end
      check("idle_after_timeout", bus.in_ready, 1);
    end else begin
      repeat (delay) tick();
      bus.det_rdy   = 1'b1;
      bus.det_match = match;
      bus.det_start = s;
      bus.det_end   = e;
      if (mode != M_ABORT) begin
        if (match) rep_q.push_back('{s, e});
        if (last) done_q.push_back(exp_count);
      end
      if (mode != M_NORMAL) bus.res_ready = 1'b0;
      tick();
      bus.det_rdy   = 1'b0;
      bus.det_match = 1'b0;
      if (!match) begin
        if (!last) check("idle_latency", bus.in_ready, 1);
      end else begin
        check("res_valid_up", bus.res_valid, 1);
        if (mode == M_ABORT) begin
          tick();
          reset = 1'b1;
          tick();
          check("abort_res_valid", bus.res_valid, 0);
          check("abort_done", bus.done, 0);
          reset = 1'b0;
          tick();
          check("abort_idle", bus.in_ready, 1);
          check("abort_count", bus.char_count, 0);
          bus.res_ready = 1'b1;
          exp_count = 0;
        end else begin
          if (mode == M_HOLD) begin
            for (int i = 0; i < 4; i++) begin
              check("hold_res_valid", bus.res_valid, 1);
              tick();
            end
            bus.res_ready = 1'b1;
          end
          tick();
          if (!last) check("idle_after_report", bus.in_ready, 1);
        end
      end
    end
    if (last && mode != M_ABORT) begin
      tick();
      check("count_clear", bus.char_count, 0);
      exp_count = 0;
    end
  endtask

  // Monitor / scoreboard.
  logic        prev_valid, prev_hs, prev_reset, prev_done;
  logic [31:0] prev_s, prev_e;
  initial begin
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_reset = 1'b1;
    prev_done  = 1'b0;
    prev_s     = '0;
    prev_e     = '0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) acc_seen++;
      if (prev_valid && !prev_hs && !prev_reset) begin
        check("res_valid_stable", bus.res_valid, 1);
        check("res_start_stable", bus.res_start, prev_s);
        check("res_end_stable", bus.res_end, prev_e);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (rep_q.size() == 0) begin
          check("unexpected_report", bus.res_valid, 0);
        end else begin
          rep_t r;
          r = rep_q.pop_front();
          check("res_start", bus.res_start, r.s);
          check("res_end", bus.res_end, r.e);
        end
      end
      if (bus.done) begin
        check("done_width", prev_done, 0);
        if (done_q.size() == 0) check("unexpected_done", bus.done, 0);
        else check("done_char_count", bus.char_count, done_q.pop_front());
      end
    end
    prev_valid <= bus.res_valid;
    prev_hs    <= bus.res_valid && bus.res_ready;
    prev_reset <= reset;
    prev_done  <= bus.done;
    prev_s     <= bus.res_start;
    prev_e     <= bus.res_end;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.in_last   = 1'b0;
    bus.det_rdy   = 1'b0;
    bus.det_match = 1'b0;
    bus.det_start = '0;
    bus.det_end   = '0;
    bus.res_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_det_reset", bus.det_reset, 1);
    check("rst_det_char", bus.det_char, 0);
    check("rst_det_last", bus.det_last, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_start", bus.res_start, 0);
    check("rst_res_end", bus.res_end, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_char_count", bus.char_count, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);

    // Single no-match character, verdict after 3 WAIT cycles.
    send_char(8'h61, 1'b0, 3, 1'b0, 0, 0, M_NORMAL, 1'b0, 1'b0);
    check("count_after_a", bus.char_count, 1);

    // Last character with a match held off by downstream for 4 cycles.
    send_char(8'h62, 1'b1, 1, 1'b1, 32'd5, 32'd9, M_HOLD, 1'b0, 1'b0);

    // Verdict in the timeout cycle takes precedence.
    send_char(8'h63, 1'b0, TO - 1, 1'b1, 32'd3, 32'd4, M_NORMAL, 1'b0, 1'b0);
    check("no_timeout_on_late_rdy", bus.timeout_err, 0);

    // Detector never answers.
    send_char(8'h64, 1'b0, -1, 1'b0, 0, 0, M_NORMAL, 1'b0, 1'b0);
    check("count_after_timeout", bus.char_count, 2);

    // Three-character stream with in_valid held high, detector noise in PULSE.
    send_char(8'h78, 1'b0, 0, 1'b0, 0, 0, M_NORMAL, 1'b1, 1'b1);
    send_char(8'h79, 1'b0, 1, 1'b1, 32'd10, 32'd20, M_NORMAL, 1'b1, 1'b1);
    send_char(8'h7A, 1'b1, 2, 1'b0, 0, 0, M_NORMAL, 1'b0, 1'b1);
    check("timeout_err_sticky", bus.timeout_err, 1);

    // Reset while REPORT is waiting on downstream.
    send_char(8'h72, 1'b1, 0, 1'b1, 32'd7, 32'd8, M_ABORT, 1'b0, 1'b0);
    check("timeout_err_cleared", bus.timeout_err, 0);

    // Normal operation resumes after the abort.
    send_char(8'h71, 1'b1, 0, 1'b0, 0, 0, M_NORMAL, 1'b0, 1'b0);

    repeat (4) tick();
    check("report_queue_drained", rep_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("accept_count", acc_seen, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regex_stream_ctrl.md
REGEX_STREAM_CTRL -- requirements
Module: regex_stream_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 2: cycles det_reset is held high per character, legal range 1..15.
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting on det_rdy, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream character valid.
REQ-006 in_ready  output  1  controller accepts a character.
REQ-007 in_char  input  8  upstream character.
REQ-008 in_last  input  1  end-of-stream marker, qualified by in_valid.
REQ-009 det_reset  output  1  per-character reset to the detector.
REQ-010 det_char  output  8  character presented to the detector.
REQ-011 det_last  output  1  end-of-stream flag to the detector.
REQ-012 det_rdy  input  1  detector evaluation complete.
REQ-013 det_match  input  1  detector match, qualified by det_rdy.
REQ-014 det_start / det_end  input  32 each  match positions, qualified by det_rdy and det_match.
REQ-015 res_valid  output  1  match report valid.
REQ-016 res_ready  input  1  downstream accepts the report.
REQ-017 res_start / res_end  output  32 each  reported match positions.
REQ-018 done  output  1  one-cycle pulse after the last character completes.
REQ-019 timeout_err  output  1  sticky flag, set when any detector wait times out.
REQ-020 char_count  output  32  characters accepted in the current stream.

Function
REQ-021 The FSM SHALL have states IDLE, PULSE, WAIT, REPORT, FINISH.
REQ-022 IDLE: in_ready=1; on in_valid=1, register in_char->det_char and in_last->det_last, increment char_count (saturate at 0xFFFFFFFF), load the pulse counter with RESET_CYCLES, go to PULSE.
REQ-023 in_ready SHALL be 0 in every state except IDLE; at most one character is in flight.
REQ-024 PULSE: det_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT; det_rdy is ignored in PULSE.
REQ-025 det_char and det_last SHALL stay stable from the cycle after acceptance until the next acceptance.
REQ-026 WAIT: det_reset=0; the wait counter starts at 0 on entry and increments each cycle.
REQ-027 WAIT with det_rdy=1 and det_match=1: latch det_start/det_end into res_start/res_end, go to REPORT.
REQ-028 WAIT with det_rdy=1 and det_match=0: go to FINISH if det_last=1, otherwise go to IDLE.
REQ-029 WAIT with det_rdy=0 and the wait counter = TIMEOUT-1: set timeout_err, treat the character as no-match (REQ-028 transition); det_rdy=1 in that same cycle takes precedence.
REQ-030 REPORT: res_valid=1 with res_start/res_end held stable; on res_ready=1 go to FINISH if det_last=1, otherwise go to IDLE.
REQ-031 res_valid SHALL NOT drop before res_ready=1.
REQ-032 FINISH: done=1 for one cycle, char_count cleared to 0, then go to IDLE.
REQ-033 Minimum per-character latency, acceptance to IDLE with no match: 1 + RESET_CYCLES + 1 cycles.
REQ-034 timeout_err SHALL be cleared only by reset.

Reset
REQ-035 A synchronous reset SHALL force the FSM to IDLE and counters to 0.
REQ-036 Reset values: in_ready=0 during reset (1 the cycle after), det_reset=1, det_char=0, det_last=0, res_valid=0, res_start=0, res_end=0, done=0, timeout_err=0, char_count=0.
REQ-037 Reset asserted in any state, including mid-PULSE, WAIT or REPORT, SHALL abort the in-flight character with no report and no done pulse.

Verification
REQ-038 Char 0x61, in_last=0, detector rdy=1 match=0 after 3 cycles -> det_reset high exactly 2 cycles, no res_valid, back to IDLE, char_count=1.
REQ-039 Char 0x62, in_last=1, detector returns match start=5 end=9, res_ready held low 4 cycles -> res_valid held with 5/9 until res_ready, then done pulses 1 cycle, char_count=0.
REQ-040 TIMEOUT=8, det_rdy never asserts -> timeout_err=1 exactly 8 cycles after WAIT entry, no res_valid, controller returns to IDLE.
REQ-041 in_valid held high for a 3-character stream -> in_ready pulses once per character; det_char changes only on acceptance.
REQ-042 Reset asserted during REPORT -> res_valid=0 and state IDLE the next cycle, no done pulse.
REQ-043 det_rdy=1 in the same cycle the wait counter hits TIMEOUT-1 -> result is taken and timeout_err stays 0.
